ifu: RTL and testbench
======================

# ifu

Instruction fetch unit feeding the decode stage (`idu`). It holds the architectural PC and reads one instruction at a time from instruction memory over a valid/ready read channel. It hands the word and its PC to `idu` as a single-cycle valid pulse, then waits for `idu` to commit the next PC before fetching again. At most one fetch is in flight; there is no prefetch.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded at reset.
- TIMEOUT, 1024, cycles allowed in REQ+RESP before a fetch is declared hung; counter width is $clog2(TIMEOUT)+1.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pc_next  in  32  next PC computed by `idu`
- pc_write_enable  in  1  `idu` commits pc_next (its send_valid && receive_ready)
- instruction  out  32  fetched word, to idu instruction_input
- pc  out  32  PC of `instruction`, to idu pc_input
- ifu_send_valid  out  1  one-cycle pulse, to idu_receive_valid
- imem_arvalid  out  1  read request valid
- imem_araddr  out  32  read address (= pc)
- imem_arready  in  1  request accepted
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- imem_rresp  in  2  response code, 2'b00 = OK
- imem_rready  out  1  ready for read data
- fetch_error  out  1  sticky error flag
- error_cause  out  2  01 misaligned pc_next, 10 bus error, 11 timeout

## Operation
- State machine states: IDLE, REQ, RESP, WAIT, ERR. All outputs are registered.
- Reset values:
  - state=IDLE, pc=RESET_PC, instruction=0.
  - ifu_send_valid=0, imem_arvalid=0, imem_rready=0.
  - fetch_error=0, error_cause=0, timeout counter=0.
- IDLE: unconditionally go to REQ next cycle and set imem_arvalid<=1.
- REQ:
  - imem_araddr=pc; imem_arvalid stays high until imem_arvalid&&imem_arready.
  - On that handshake: arvalid<=0, rready<=1, go to RESP.
- RESP:
  - On imem_rvalid with imem_rresp==0: instruction<=imem_rdata, rready<=0, ifu_send_valid<=1, go to WAIT.
  - On imem_rvalid with imem_rresp!=0: go to ERR, cause 10; instruction is not updated.
  - imem_rvalid is ignored in every state other than RESP.
- WAIT:
  - ifu_send_valid<=0 on the first WAIT cycle, so it is high for exactly one cycle.
  - On pc_write_enable: if pc_next[1:0]==0, pc<=pc_next, arvalid<=1, go to REQ. Otherwise go to ERR, cause 11? No: go to ERR with cause 01, and pc is unchanged.
  - pc_write_enable in IDLE/REQ/RESP/ERR is ignored.
- Timeout:
  - Counter clears on entry to REQ and increments every cycle in REQ or RESP.
  - When it reaches TIMEOUT-1 without completion: go to ERR, cause 11. Drop arvalid/rready.
- ERR: fetch_error=1; arvalid, rready and send_valid are 0. Only rst leaves ERR.
- instruction and pc stay stable from the send pulse until the next successful response / pc_next commit.
- rst at any point (mid-REQ, mid-RESP) returns to reset values immediately. An outstanding memory response after reset is ignored because the block is in IDLE.

## Timing
- Reset release at edge E0: IDLE during E0..E1, imem_arvalid=1 from E1.
- AR handshake in cycle N: imem_rready=1 in N+1.
- rvalid accepted in cycle M: instruction and ifu_send_valid valid in M+1; send_valid low in M+2.
- pc_write_enable in cycle K (in WAIT): new pc and imem_arvalid=1 in K+1.
- Best-case loop (arready=1, rvalid one cycle after handshake, idu commit 1 cycle after pulse): 4 cycles per instruction.
- The same-cycle combination of arready and state entry is legal: a handshake occurs on the first cycle arvalid is high if arready=1.

## Test plan
- Reset, memory with zero-wait arready, rdata=32'h00100093 one cycle later:
  - araddr=32'h8000_0000 at E1.
  - ifu_send_valid pulses once with instruction=32'h00100093, pc=32'h8000_0000.
- After the pulse, drive pc_next=32'h8000_0010 with pc_write_enable one cycle:
  - next araddr=32'h8000_0010; pc output updates to 32'h8000_0010.
- arready held low 5 cycles, rvalid delayed 3 cycles:
  - arvalid stays high and araddr stays stable until accept.
  - Exactly one send pulse results; no timeout.
- rresp=2'b10 on response: fetch_error=1, error_cause=10, no send pulse, arvalid stays 0 until rst.
- pc_next=32'h8000_0002 committed: fetch_error=1, error_cause=01, no new request.
- Tie arready=1 and rvalid=0 for TIMEOUT cycles: error_cause=11. Then assert rst mid-ERR: all outputs return to reset values and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: one fetch in flight over a valid/ready read
// channel, word handed to decode as a single-cycle pulse.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        pc_write_enable,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        ifu_send_valid,
  output logic        imem_arvalid,
  output logic [31:0] imem_araddr,
  input  logic        imem_arready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  imem_rresp,
  output logic        imem_rready,
  output logic        fetch_error,
  output logic [1:0]  error_cause
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  localparam logic [1:0] C_MISALIGN = 2'b01;
  localparam logic [1:0] C_BUS      = 2'b10;
  localparam logic [1:0] C_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, REQ, RESP, WAIT, ERR
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          send_q, send_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic          err_q, err_d;
  logic [1:0]    cause_q, cause_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    send_d    = send_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    err_d     = err_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        state_d   = REQ;
        arvalid_d = 1'b1;
        cnt_d     = '0;
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (arvalid_q && imem_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RESP;
        end else if (cnt_q >= TMAX) begin
          state_d   = ERR;
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          err_d     = 1'b1;
          cause_d   = C_TIMEOUT;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (imem_rvalid) begin
          rready_d = 1'b0;
          if (imem_rresp == 2'b00) begin
            instr_d = imem_rdata;
            send_d  = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            cause_d = C_BUS;
          end
        end else if (cnt_q >= TMAX) begin
          state_d   = ERR;
          arvalid_d = 1'b0;
          rready_d  = 1'b0;
          err_d     = 1'b1;
          cause_d   = C_TIMEOUT;
        end
      end
      WAIT: begin
        send_d = 1'b0;
        if (pc_write_enable) begin
          if (pc_next[1:0] == 2'b00) begin
            pc_d      = pc_next;
            arvalid_d = 1'b1;
            cnt_d     = '0;
            state_d   = REQ;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
            cause_d = C_MISALIGN;
          end
        end
      end
      ERR: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        send_d    = 1'b0;
        err_d     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      send_q    <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
      cause_q   <= 2'b00;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      send_q    <= send_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      err_q     <= err_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
    end
  end

  assign instruction    = instr_q;
  assign pc             = pc_q;
  assign ifu_send_valid = send_q;
  assign imem_arvalid   = arvalid_q;
  assign imem_araddr    = pc_q;
  assign imem_rready    = rready_q;
  assign fetch_error    = err_q;
  assign error_cause    = cause_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: fetch loop, stalls, bus error,
// misaligned commit, timeout and reset out of ERR.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_next;
  logic        pc_write_enable;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        ifu_send_valid;
  logic        imem_arvalid;
  logic [31:0] imem_araddr;
  logic        imem_arready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [1:0]  imem_rresp;
  logic        imem_rready;
  logic        fetch_error;
  logic [1:0]  error_cause;

  int checks = 0;
  int errors = 0;
  int n;
  int pulses;

  ifu dut (
    .clk             (clk),
    .rst             (rst),
    .pc_next         (pc_next),
    .pc_write_enable (pc_write_enable),
    .instruction     (instruction),
    .pc              (pc),
    .ifu_send_valid  (ifu_send_valid),
    .imem_arvalid    (imem_arvalid),
    .imem_araddr     (imem_araddr),
    .imem_arready    (imem_arready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .imem_rresp      (imem_rresp),
    .imem_rready     (imem_rready),
    .fetch_error     (fetch_error),
    .error_cause     (error_cause)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h8000_0000);
    chk({tag, "_instr"}, instruction, 32'h0);
    chk({tag, "_send"}, {31'b0, ifu_send_valid}, 32'h0);
    chk({tag, "_arvalid"}, {31'b0, imem_arvalid}, 32'h0);
    chk({tag, "_rready"}, {31'b0, imem_rready}, 32'h0);
    chk({tag, "_ferr"}, {31'b0, fetch_error}, 32'h0);
    chk({tag, "_cause"}, {30'b0, error_cause}, 32'h0);
  endtask

  initial begin
    rst             = 1'b1;
    pc_next         = '0;
    pc_write_enable = 1'b0;
    imem_arready    = 1'b0;
    imem_rvalid     = 1'b0;
    imem_rdata      = '0;
    imem_rresp      = 2'b00;
    tick();
    tick();
    chk_reset("rst0");

    // zero-wait fetch of the first word
    rst          = 1'b0;
    imem_arready = 1'b1;
    tick();
    chk("e1_arvalid", {31'b0, imem_arvalid}, 32'h1);
    chk("e1_araddr", imem_araddr, 32'h8000_0000);
    tick();
    chk("hs_rready", {31'b0, imem_rready}, 32'h1);
    chk("hs_arvalid", {31'b0, imem_arvalid}, 32'h0);
    imem_arready = 1'b0;
    imem_rvalid  = 1'b1;
    imem_rdata   = 32'h0010_0093;
    tick();
    imem_rvalid = 1'b0;
    chk("p1_send", {31'b0, ifu_send_valid}, 32'h1);
    chk("p1_instr", instruction, 32'h0010_0093);
    chk("p1_pc", pc, 32'h8000_0000);
    chk("p1_rready", {31'b0, imem_rready}, 32'h0);
    tick();
    chk("p1_send_low", {31'b0, ifu_send_valid}, 32'h0);
    chk("p1_instr_hold", instruction, 32'h0010_0093);

    // commit next pc
    pc_next         = 32'h8000_0010;
    pc_write_enable = 1'b1;
    tick();
    pc_write_enable = 1'b0;
    chk("c1_pc", pc, 32'h8000_0010);
    chk("c1_araddr", imem_araddr, 32'h8000_0010);
    chk("c1_arvalid", {31'b0, imem_arvalid}, 32'h1);

    // stalled request; stray rvalid outside RESP must be ignored
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hffff_ffff;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_arvalid", {31'b0, imem_arvalid}, 32'h1);
      chk("st_araddr", imem_araddr, 32'h8000_0010);
    end
    chk("st_instr", instruction, 32'h0010_0093);
    imem_rvalid  = 1'b0;
    imem_arready = 1'b1;
    tick();
    imem_arready = 1'b0;
    chk("st_rready", {31'b0, imem_rready}, 32'h1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ifu_send_valid) pulses++;
    end
    chk("st_rready_hold", {31'b0, imem_rready}, 32'h1);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0020_8113;
    tick();
    imem_rvalid = 1'b0;
    if (ifu_send_valid) pulses++;
    chk("p2_instr", instruction, 32'h0020_8113);
    chk("p2_pc", pc, 32'h8000_0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ifu_send_valid) pulses++;
    end
    chk("p2_pulses", pulses, 32'd1);
    chk("p2_noerr", {31'b0, fetch_error}, 32'h0);

    // misaligned commit
    pc_next         = 32'h8000_0002;
    pc_write_enable = 1'b1;
    tick();
    pc_write_enable = 1'b0;
    chk("ma_ferr", {31'b0, fetch_error}, 32'h1);
    chk("ma_cause", {30'b0, error_cause}, 32'h1);
    chk("ma_pc", pc, 32'h8000_0010);
    imem_arready = 1'b1;
    tick();
    tick();
    chk("ma_arvalid", {31'b0, imem_arvalid}, 32'h0);

    // reset, then bus error on the response
    rst = 1'b1;
    tick();
    chk_reset("rst1");
    rst = 1'b0;
    tick();
    chk("be_araddr", imem_araddr, 32'h8000_0000);
    chk("be_arvalid", {31'b0, imem_arvalid}, 32'h1);
    tick();
    imem_arready = 1'b0;
    imem_rvalid  = 1'b1;
    imem_rresp   = 2'b10;
    imem_rdata   = 32'hdead_beef;
    tick();
    imem_rvalid = 1'b0;
    imem_rresp  = 2'b00;
    chk("be_ferr", {31'b0, fetch_error}, 32'h1);
    chk("be_cause", {30'b0, error_cause}, 32'h2);
    chk("be_send", {31'b0, ifu_send_valid}, 32'h0);
    chk("be_instr", instruction, 32'h0);
    imem_arready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("be_arvalid_hold", {31'b0, imem_arvalid}, 32'h0);

    // timeout: request accepted, response never arrives
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("to_arvalid", {31'b0, imem_arvalid}, 32'h1);
    n      = 0;
    pulses = 0;
    while (!fetch_error && n < 1200) begin
      tick();
      n++;
      if (ifu_send_valid) pulses++;
    end
    chk("to_cycles", n, 32'd1024);
    chk("to_cause", {30'b0, error_cause}, 32'h3);
    chk("to_arvalid_low", {31'b0, imem_arvalid}, 32'h0);
    chk("to_rready_low", {31'b0, imem_rready}, 32'h0);
    chk("to_pulses", pulses, 32'd0);

    // reset out of ERR restarts at RESET_PC
    rst = 1'b1;
    tick();
    chk_reset("rst2");
    rst = 1'b0;
    tick();
    chk("rs_arvalid", {31'b0, imem_arvalid}, 32'h1);
    chk("rs_araddr", imem_araddr, 32'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
